// File: rtl/cic_interpolator_if.sv
// rtl/cic_interpolator_if.sv - sample handshake between a baseband source and the CIC interpolator
interface cic_interpolator_if;
    logic signed [7:0] d_in;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] d_out;
    logic              d_out_valid;

    modport master (
        output d_in,
        output in_valid,
        input  in_ready,
        input  d_out,
        input  d_out_valid
    );

    modport slave (
        input  d_in,
        input  in_valid,
        output in_ready,
        output d_out,
        output d_out_valid
    );
endinterface

// File: rtl/cic_interpolator.sv
// rtl/cic_interpolator.sv - five-stage CIC interpolator, 8-bit in/out, ratio R at run time
// Macro CIC_INTERP_SAT_EN makes the output clip saturate instead of wrap.
module cic_interpolator #(
    parameter int width = 80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       interpolation_ratio,
    input  logic [6:0]        out_shift,
    cic_interpolator_if.slave bus,
    output logic              d_clk,
    output logic              underrun
);
    typedef enum logic {IDLE, RUN} state_t;
    typedef logic signed [width-1:0] acc_t;

    state_t      state;
    logic [15:0] count;
    logic [15:0] ratio;
    logic        strobe;
    logic        accept;
    acc_t        comb [6];
    acc_t        comb_prev [5];
    acc_t        up;
    logic        up_v;
    acc_t        u;
    acc_t        integ [5];
    logic [7:0]  d_next;

    assign ratio  = (interpolation_ratio == 16'd0) ? 16'd1 : interpolation_ratio;
    assign strobe = (state == IDLE) ? bus.in_valid : (count == 16'd0);
    assign accept = strobe & bus.in_valid;
    assign u      = up_v ? up : '0;

    // in_ready is gated by rst so it reads 0 while reset is held, not the IDLE value
    assign bus.in_ready = ~rst & ((state == IDLE) | (count == 16'd0));

    always_comb begin
        comb[0] = accept ? {{(width-8){bus.d_in[7]}}, bus.d_in} : '0;
        for (int k = 1; k < 6; k++)
            comb[k] = comb[k-1] - comb_prev[k-1];
    end

`ifdef CIC_INTERP_SAT_EN
    localparam acc_t pos_lim = acc_t'(127);
    localparam acc_t neg_lim = acc_t'(-128);
    acc_t shifted;

    assign shifted = integ[4] >>> out_shift;
    assign d_next  = (shifted > pos_lim) ? 8'h7f :
                     (shifted < neg_lim) ? 8'h80 : shifted[7:0];
`else
    assign d_next = 8'(integ[4] >>> out_shift);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            count           <= '0;
            up              <= '0;
            up_v            <= 1'b0;
            bus.d_out       <= '0;
            bus.d_out_valid <= 1'b0;
            d_clk           <= 1'b0;
            underrun        <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                comb_prev[k] <= '0;
                integ[k]     <= '0;
            end
        end else begin
            if (strobe) begin
                for (int k = 0; k < 5; k++)
                    comb_prev[k] <= comb[k];
                up <= comb[5];
            end
            up_v <= strobe;

            if (state == RUN) begin
                integ[0] <= integ[0] + u;
                for (int k = 1; k < 5; k++)
                    integ[k] <= integ[k] + integ[k-1];
            end

            bus.d_out <= d_next;
            if (strobe)
                bus.d_out_valid <= 1'b1;

            if (strobe)
                d_clk <= 1'b1;
            else if ((state == RUN) && (ratio > 16'd1) && (count == (ratio >> 1)))
                d_clk <= 1'b0;

            if ((state == RUN) && strobe && !bus.in_valid)
                underrun <= 1'b1;

            // wrap on >= so a ratio lowered below the current phase still wraps next cycle
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state <= RUN;
                        count <= (ratio <= 16'd1) ? 16'd0 : 16'd1;
                    end
                end
                RUN: begin
                    count <= (count >= ratio - 16'd1) ? 16'd0 : count + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
